// File: rtl/adbg_or1k_ctrl_access_if.sv
// Bundles the TAP qualifiers, serial data and control-register signals
// that connect the OR1K control-access engine to its surroundings.
interface adbg_or1k_ctrl_access_if #(
    parameter int NB_CORES = 4
);
    localparam int W = NB_CORES * 2;

    logic          module_select_i;
    logic          capture_dr_i;
    logic          shift_dr_i;
    logic          update_dr_i;
    logic          tdi_i;
    logic          tdo_o;
    logic          we_o;
    logic [W-1:0]  data_o;
    logic [W-1:0]  ctrl_reg_i;
    logic          crc_err_o;

    // TAP / status-register side: drives qualifiers and read-back value
    modport master (
        output module_select_i,
        output capture_dr_i,
        output shift_dr_i,
        output update_dr_i,
        output tdi_i,
        output ctrl_reg_i,
        input  tdo_o,
        input  we_o,
        input  data_o,
        input  crc_err_o
    );

    // Command engine side
    modport slave (
        input  module_select_i,
        input  capture_dr_i,
        input  shift_dr_i,
        input  update_dr_i,
        input  tdi_i,
        input  ctrl_reg_i,
        output tdo_o,
        output we_o,
        output data_o,
        output crc_err_o
    );
endinterface

// File: rtl/adbg_or1k_ctrl_access.sv
// JTAG-side command engine for the OR1K per-core stall/reset control word.
// Decodes a 4-bit opcode shifted in LSB first, then either receives a
// CRC-protected control word (WRITE) or returns a snapshot of the current
// control word followed by its CRC-32 (READ). Runs entirely on TCK.
module adbg_or1k_ctrl_access #(
    parameter int NB_CORES = 4
) (
    input  logic                          tck_i,
    input  logic                          tlr_i,
    adbg_or1k_ctrl_access_if.slave        bus
);
    localparam int W    = NB_CORES * 2;
    localparam int SRW  = (W > 32) ? W : 32;
    localparam int CW   = $clog2(SRW) + 1;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    localparam logic [3:0] OP_WRITE = 4'h9;
    localparam logic [3:0] OP_READ  = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_CRC  = 3'd3,
        ST_WR_DONE = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_RD_CRC  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // One bit of the reflected CRC-32 register update
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? CRC_POLY : 32'h0000_0000);
    endfunction

    state_t           state_r,    state_nxt_s;
    logic [CW-1:0]    cnt_r,      cnt_nxt_s;
    logic [3:0]       op_r,       op_nxt_s;
    logic [W-1:0]     data_sr_r,  data_sr_nxt_s;
    logic [31:0]      rx_crc_r,   rx_crc_nxt_s;
    logic [SRW-1:0]   out_sr_r,   out_sr_nxt_s;
    logic [31:0]      crc_r,      crc_nxt_s;
    logic             we_r,       we_nxt_s;
    logic [W-1:0]     data_r,     data_nxt_s;
    logic             crc_err_r,  crc_err_nxt_s;

    logic             sel_s;
    logic [3:0]       op_full_s;
    logic [31:0]      rd_crc_step_s;

    assign sel_s         = bus.module_select_i;
    assign op_full_s     = {bus.tdi_i, op_r[3:1]};
    assign rd_crc_step_s = crc32_step(crc_r, out_sr_r[0]);

    // Serial output only carries data while a read is streaming and the module is selected
    assign bus.tdo_o     = sel_s && ((state_r == ST_RD_DATA) || (state_r == ST_RD_CRC)) && out_sr_r[0];
    assign bus.we_o      = we_r;
    assign bus.data_o    = data_r;
    assign bus.crc_err_o = crc_err_r;

    // Next-state and datapath decode; capture beats update beats shift
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        op_nxt_s      = op_r;
        data_sr_nxt_s = data_sr_r;
        rx_crc_nxt_s  = rx_crc_r;
        out_sr_nxt_s  = out_sr_r;
        crc_nxt_s     = crc_r;
        we_nxt_s      = 1'b0;
        data_nxt_s    = data_r;
        crc_err_nxt_s = crc_err_r;

        if (sel_s && bus.capture_dr_i) begin
            state_nxt_s = ST_OPCODE;
            cnt_nxt_s   = {CW{1'b0}};
            crc_nxt_s   = CRC_INIT;
        end else if (sel_s && bus.update_dr_i) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
            if (state_r == ST_WR_DONE) begin
                if (rx_crc_r == crc_r) begin
                    we_nxt_s      = 1'b1;
                    data_nxt_s    = data_sr_r;
                    crc_err_nxt_s = 1'b0;
                end else begin
                    crc_err_nxt_s = 1'b1;
                end
            end else begin
                crc_err_nxt_s = crc_err_r;
            end
        end else if (sel_s && bus.shift_dr_i) begin
            case (state_r)
                ST_OPCODE: begin
                    op_nxt_s = op_full_s;
                    if (cnt_r == CW'(3)) begin
                        cnt_nxt_s = {CW{1'b0}};
                        case (op_full_s)
                            OP_WRITE: state_nxt_s = ST_WR_DATA;
                            OP_READ: begin
                                state_nxt_s  = ST_RD_DATA;
                                out_sr_nxt_s = SRW'(bus.ctrl_reg_i);
                                crc_nxt_s    = CRC_INIT;
                            end
                            default: state_nxt_s = ST_DONE;
                        endcase
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_WR_DATA: begin
                    data_sr_nxt_s = {bus.tdi_i, data_sr_r[W-1:1]};
                    crc_nxt_s     = crc32_step(crc_r, bus.tdi_i);
                    if (cnt_r == CW'(W - 1)) begin
                        state_nxt_s = ST_WR_CRC;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_WR_CRC: begin
                    rx_crc_nxt_s = {bus.tdi_i, rx_crc_r[31:1]};
                    if (cnt_r == CW'(31)) begin
                        state_nxt_s = ST_WR_DONE;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_RD_DATA: begin
                    crc_nxt_s = rd_crc_step_s;
                    if (cnt_r == CW'(W - 1)) begin
                        // CRC already folds in the bit leaving on this edge
                        state_nxt_s  = ST_RD_CRC;
                        cnt_nxt_s    = {CW{1'b0}};
                        out_sr_nxt_s = SRW'(rd_crc_step_s);
                    end else begin
                        cnt_nxt_s    = cnt_r + CW'(1);
                        out_sr_nxt_s = out_sr_r >> 1;
                    end
                end
                ST_RD_CRC: begin
                    out_sr_nxt_s = out_sr_r >> 1;
                    if (cnt_r == CW'(31)) begin
                        state_nxt_s = ST_DONE;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_IDLE, ST_WR_DONE, ST_DONE: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and datapath registers; TLR returns everything to reset values immediately
    always_ff @(posedge tck_i or posedge tlr_i) begin
        if (tlr_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            op_r      <= 4'h0;
            data_sr_r <= {W{1'b0}};
            rx_crc_r  <= 32'h0000_0000;
            out_sr_r  <= {SRW{1'b0}};
            crc_r     <= CRC_INIT;
            we_r      <= 1'b0;
            data_r    <= {W{1'b0}};
            crc_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            op_r      <= op_nxt_s;
            data_sr_r <= data_sr_nxt_s;
            rx_crc_r  <= rx_crc_nxt_s;
            out_sr_r  <= out_sr_nxt_s;
            crc_r     <= crc_nxt_s;
            we_r      <= we_nxt_s;
            data_r    <= data_nxt_s;
            crc_err_r <= crc_err_nxt_s;
        end
    end
endmodule
